// File: rtl/pcs_gen_pkg.sv
// Shared types and constants for the GMII frame generator: FSM states,
// payload pattern encodings, framing bytes and the PRBS8 polynomial.
package pcs_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_IPG,
        ST_DONE
    } gen_state_e;

    typedef enum logic [1:0] {
        MODE_INC       = 2'd0,
        MODE_FIXED     = 2'd1,
        MODE_PRBS      = 2'd2,
        MODE_FRAME_INC = 2'd3
    } pattern_mode_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Feedback taps s7^s5^s4^s3, shifted in at bit 0.
    localparam logic [7:0] PRBS8_TAPS    = 8'hB8;

    function automatic logic [7:0] prbs8_next(input logic [7:0] s);
        return {s[6:0], ^(s & PRBS8_TAPS)};
    endfunction

endpackage

// File: rtl/prbs8_lfsr.sv
// 8-bit Fibonacci LFSR for the PRBS payload; load has priority over advance.
module prbs8_lfsr
    import pcs_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '1;
        end else if (load) begin
            lfsr_q <= seed;
        end else if (advance) begin
            lfsr_q <= prbs8_next(lfsr_q);
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/gmii_frame_generator.sv
// Programmable GMII transmit frame source: preamble, SFD, patterned payload
// and IPG, repeated num_frames times per launch, with optional TX_ER injection.
module gmii_frame_generator
    import pcs_gen_pkg::*;
#(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IPG_MIN      = 12,
    parameter logic [7:0]  LFSR_SEED    = 8'hFF
) (
    input  logic             Clk,
    input  logic             mr_main_reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       ipg_len,
    input  logic [1:0]       mode,
    input  logic [7:0]       fixed_byte,
    input  logic             err_en,
    input  logic [LEN_W-1:0] err_idx,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam logic [7:0]       IPG_MIN_B = 8'(IPG_MIN);
    localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(PREAMBLE_LEN - 1);

    gen_state_e       state, next_state;
    logic [LEN_W-1:0] cnt;

    logic [CNT_W-1:0] nf_l;
    logic [LEN_W-1:0] len_l;
    logic [7:0]       ipg_l;
    pattern_mode_e    mode_l;
    logic [7:0]       fixed_l;
    logic             err_en_l;
    logic [LEN_W-1:0] err_idx_l;
    logic             stop_seen;

    logic             accept;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic [7:0]       lfsr_out;
    logic [7:0]       payload_byte;
    logic [7:0]       ipg_clamped;

    assign accept      = (state == ST_IDLE) && start;
    assign ipg_clamped = (ipg_len < IPG_MIN_B) ? IPG_MIN_B : ipg_len;
    assign lfsr_load   = (next_state == ST_PREAMBLE) && (state != ST_PREAMBLE);
    assign lfsr_adv    = (state == ST_PAYLOAD);

    prbs8_lfsr u_prbs (
        .clk     (Clk),
        .rst     (mr_main_reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (LFSR_SEED),
        .out     (lfsr_out)
    );

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:     if (start) next_state = ST_LOAD;
            ST_LOAD:     next_state = (nf_l == '0) ? ST_DONE : ST_PREAMBLE;
            ST_PREAMBLE: if (cnt == PRE_LAST) next_state = ST_SFD;
            ST_SFD:      next_state = (len_l == '0) ? ST_IPG : ST_PAYLOAD;
            ST_PAYLOAD:  if (cnt == len_l - LEN_W'(1)) next_state = ST_IPG;
            ST_IPG: begin
                if (cnt == LEN_W'(ipg_l) - LEN_W'(1)) begin
                    next_state = ((frames_sent == nf_l) || stop_seen || stop)
                                 ? ST_DONE : ST_PREAMBLE;
                end
            end
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        payload_byte = '0;
        unique case (mode_l)
            MODE_INC:       payload_byte = cnt[7:0];
            MODE_FIXED:     payload_byte = fixed_l;
            MODE_PRBS:      payload_byte = lfsr_out;
            MODE_FRAME_INC: payload_byte = cnt[7:0] + frames_sent[7:0];
            default:        payload_byte = '0;
        endcase
    end

    // Per-state cycle counter: restarts on every state change, idle at zero.
    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            cnt <= '0;
        end else if ((next_state != state) || (state == ST_IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            nf_l      <= '0;
            len_l     <= '0;
            ipg_l     <= IPG_MIN_B;
            mode_l    <= MODE_INC;
            fixed_l   <= '0;
            err_en_l  <= 1'b0;
            err_idx_l <= '0;
        end else if (accept) begin
            nf_l      <= num_frames;
            len_l     <= frame_len;
            ipg_l     <= ipg_clamped;
            mode_l    <= pattern_mode_e'(mode);
            fixed_l   <= fixed_byte;
            err_en_l  <= err_en;
            err_idx_l <= err_idx;
        end
    end

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            stop_seen   <= 1'b0;
            frames_sent <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == ST_DONE) begin
                stop_seen <= 1'b0;
            end else if (stop && (state != ST_IDLE)) begin
                stop_seen <= 1'b1;
            end

            if (accept) begin
                frames_sent <= '0;
            end else if ((next_state == ST_IPG) && (state != ST_IPG)) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end

            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_DONE);
        end
    end

    // Line outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            TXD   <= '0;
            TX_EN <= 1'b0;
            TX_ER <= 1'b0;
        end else begin
            TXD   <= '0;
            TX_EN <= 1'b0;
            TX_ER <= 1'b0;
            unique case (state)
                ST_PREAMBLE: begin
                    TXD   <= PREAMBLE_BYTE;
                    TX_EN <= 1'b1;
                end
                ST_SFD: begin
                    TXD   <= SFD_BYTE;
                    TX_EN <= 1'b1;
                end
                ST_PAYLOAD: begin
                    TXD   <= payload_byte;
                    TX_EN <= 1'b1;
                    TX_ER <= err_en_l && (cnt == err_idx_l);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_generator.sv
// Directed bench for gmii_frame_generator: hand-computed byte sequences,
// IPG lengths and status flags checked with immediate assertions.
module tb_gmii_frame_generator;

    logic        clk = 1'b0;
    logic        mr_main_reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] num_frames = '0;
    logic [15:0] frame_len = '0;
    logic [7:0]  ipg_len = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  fixed_byte = '0;
    logic        err_en = 1'b0;
    logic [15:0] err_idx = '0;
    logic [7:0]  TXD;
    logic        TX_EN;
    logic        TX_ER;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int          n_assert = 0;
    int          n_fail = 0;
    int          stop_idx = -1;
    logic [7:0]  exp_pl [0:15];

    gmii_frame_generator #(
        .LEN_W        (16),
        .CNT_W        (16),
        .PREAMBLE_LEN (7),
        .IPG_MIN      (12),
        .LFSR_SEED    (8'hFF)
    ) dut (
        .Clk           (clk),
        .mr_main_reset (mr_main_reset),
        .start         (start),
        .stop          (stop),
        .num_frames    (num_frames),
        .frame_len     (frame_len),
        .ipg_len       (ipg_len),
        .mode          (mode),
        .fixed_byte    (fixed_byte),
        .err_en        (err_en),
        .err_idx       (err_idx),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are scrambled right after the start edge to show they were latched.
    task automatic launch(input int nf, input int len, input int ipg, input int md,
                          input int fb, input int ee, input int ei);
        num_frames = 16'(nf);
        frame_len  = 16'(len);
        ipg_len    = 8'(ipg);
        mode       = 2'(md);
        fixed_byte = 8'(fb);
        err_en     = 1'(ee);
        err_idx    = 16'(ei);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_frames = 16'd5;
        frame_len  = 16'd9;
        ipg_len    = 8'd1;
        mode       = ~mode;
        fixed_byte = ~fixed_byte;
        err_en     = ~err_en;
        err_idx    = 16'd0;
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_fs_clear", 32'(frames_sent), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int len, input int err_i, input int budget);
        int waited;
        int seen;
        waited = 0;
        seen = 0;
        while ((seen == 0) && (waited < budget)) begin
            @(negedge clk);
            waited++;
            if (TX_EN === 1'b1) seen = 1;
        end
        chk({tag, "_txen_start"}, 32'(seen), 32'd1);
        if (seen != 0) begin
            for (int p = 0; p < 7; p++) begin
                if (p > 0) @(negedge clk);
                chk({tag, "_pre"}, {22'd0, TX_ER, TX_EN, TXD}, {22'd0, 1'b0, 1'b1, 8'h55});
            end
            @(negedge clk);
            chk({tag, "_sfd"}, {22'd0, TX_ER, TX_EN, TXD}, {22'd0, 1'b0, 1'b1, 8'hD5});
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                stop = (i == stop_idx);
                chk({tag, "_pay"}, {22'd0, TX_ER, TX_EN, TXD},
                    {22'd0, (i == err_i), 1'b1, exp_pl[i]});
            end
            stop = 1'b0;
        end
    endtask

    task automatic check_gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_gap"}, {22'd0, TX_ER, TX_EN, TXD}, 32'd0);
        end
    endtask

    // done is high on the last idle line cycle; busy drops on the next one.
    task automatic finish_launch(input string tag, input int nf);
        check_gap(tag, 12);
        chk({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_frames_sent"}, 32'(frames_sent), 32'(nf));
    endtask

    initial begin
        int txen_cnt;
        int seen;
        int waited;

        // Reset state
        @(negedge clk);
        chk("rst_txd", 32'(TXD), 32'd0);
        chk("rst_txen", 32'(TX_EN), 32'd0);
        chk("rst_txer", 32'(TX_ER), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fs", 32'(frames_sent), 32'd0);
        mr_main_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // 1: single frame, incrementing payload, first 0x55 two edges after start
        for (int i = 0; i < 4; i++) exp_pl[i] = 8'(i);
        launch(1, 4, 12, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_latency_txen", 32'(TX_EN), 32'd0);
        check_frame("t1", 4, -1, 1);
        finish_launch("t1", 1);

        // 2: fixed byte, ipg 3 clamped to 12 idle cycles between frames
        for (int i = 0; i < 3; i++) exp_pl[i] = 8'hA5;
        launch(2, 3, 3, 1, 8'hA5, 0, 0);
        check_frame("t2_f1", 3, -1, 5);
        check_gap("t2_ipg", 12);
        chk("t2_fs_mid", 32'(frames_sent), 32'd1);
        check_frame("t2_f2", 3, -1, 1);
        finish_launch("t2", 2);

        // 3: error injection on byte 2, then err_idx == frame_len
        for (int i = 0; i < 5; i++) exp_pl[i] = 8'(i);
        launch(1, 5, 12, 0, 0, 1, 2);
        check_frame("t3a", 5, 2, 5);
        finish_launch("t3a", 1);
        launch(1, 5, 12, 0, 0, 1, 5);
        check_frame("t3b", 5, -1, 5);
        finish_launch("t3b", 1);

        // 4: PRBS reseeded per frame
        exp_pl[0] = 8'hFF; exp_pl[1] = 8'hFE; exp_pl[2] = 8'hFC;
        exp_pl[3] = 8'hF8; exp_pl[4] = 8'hF0; exp_pl[5] = 8'hE1;
        launch(2, 6, 12, 2, 0, 0, 0);
        check_frame("t4_f1", 6, -1, 5);
        check_gap("t4_ipg", 12);
        check_frame("t4_f2", 6, -1, 1);
        finish_launch("t4", 2);

        // 4b: frame-indexed incrementing
        launch(3, 2, 12, 3, 0, 0, 0);
        exp_pl[0] = 8'h00; exp_pl[1] = 8'h01;
        check_frame("t4m3_f1", 2, -1, 5);
        check_gap("t4m3_ipg1", 12);
        exp_pl[0] = 8'h01; exp_pl[1] = 8'h02;
        check_frame("t4m3_f2", 2, -1, 1);
        check_gap("t4m3_ipg2", 12);
        exp_pl[0] = 8'h02; exp_pl[1] = 8'h03;
        check_frame("t4m3_f3", 2, -1, 1);
        finish_launch("t4m3", 3);

        // 5: reset during payload byte 2 of the second frame
        for (int i = 0; i < 4; i++) exp_pl[i] = 8'(i);
        launch(2, 4, 12, 0, 0, 1, 2);
        check_frame("t5_f1", 4, 2, 5);
        check_gap("t5_ipg", 12);
        check_frame("t5_f2", 3, 2, 1);
        chk("t5_fs_before", 32'(frames_sent), 32'd1);
        mr_main_reset = 1'b1;
        #1;
        chk("t5_async_txen", 32'(TX_EN), 32'd0);
        chk("t5_async_txer", 32'(TX_ER), 32'd0);
        chk("t5_async_txd", 32'(TXD), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_fs", 32'(frames_sent), 32'd0);
        @(negedge clk);
        mr_main_reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_txen", 32'(TX_EN), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        launch(1, 4, 12, 0, 0, 0, 0);
        check_frame("t5_after", 4, -1, 5);
        finish_launch("t5_after", 1);

        // 6a: num_frames = 0
        launch(0, 4, 12, 0, 0, 0, 0);
        txen_cnt = 0;
        seen = 0;
        waited = 0;
        while ((seen == 0) && (waited < 6)) begin
            @(negedge clk);
            waited++;
            if (TX_EN === 1'b1) txen_cnt++;
            if (done === 1'b1) seen = 1;
        end
        chk("t6a_done_seen", 32'(seen), 32'd1);
        chk("t6a_done_latency", 32'(waited), 32'd1);
        chk("t6a_no_txen", 32'(txen_cnt), 32'd0);
        @(negedge clk);
        chk("t6a_busy_low", 32'(busy), 32'd0);
        chk("t6a_fs", 32'(frames_sent), 32'd0);

        // 6b: frame_len = 0
        launch(1, 0, 12, 0, 0, 0, 0);
        check_frame("t6b", 0, -1, 5);
        finish_launch("t6b", 1);

        // 6c: start while busy and in the DONE cycle is ignored
        for (int i = 0; i < 3; i++) exp_pl[i] = 8'(i);
        launch(2, 3, 12, 0, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_frame("t6c_f1", 3, -1, 5);
        check_gap("t6c_ipg", 12);
        check_frame("t6c_f2", 3, -1, 1);
        check_gap("t6c_end", 12);
        chk("t6c_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6c_frames_sent", 32'(frames_sent), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6c_no_relaunch", {30'd0, busy, TX_EN}, 32'd0);
        end

        // 6d: stop during frame 1 of 5
        stop_idx = 1;
        launch(5, 3, 12, 0, 0, 0, 0);
        check_frame("t6d", 3, -1, 5);
        stop_idx = -1;
        finish_launch("t6d", 1);
        check_gap("t6d_quiet", 6);
        chk("t6d_busy_quiet", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
